regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
- Scoreboard, write-port arbiter and drain controller for the operand-fetch stage and its 16x64 register file.
- Tracks in-flight destination-register writes and stalls operand fetch on RAW and write-count hazards.
- Shares the single register-file write port between the ALU and memory write-back requesters.
- Provides a drain handshake so the pipeline can be quiesced before a mode change or a halt.

Parameters:
- NUM_REGS, 16, number of architectural registers
- ADDR_W, 4, register address width
- DATA_W, 64, register data width
- CNT_W, 2, width of each per-register pending-write counter (saturates at 2^CNT_W-1)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- if_valid  in  1  fetched instruction present
- if_instr  in  24  fetched instruction: rs1=[15:12], rs2=[19:16], rd=[23:20]
- dec_writes_reg  in  1  decoded instruction writes rd
- dec_uses_rs2  in  1  decoded instruction reads rs2
- of_issue  out  1  instruction accepted this cycle (combinational)
- of_stall  out  1  if_valid held this cycle (combinational)
- alu_wb_valid / alu_wb_addr / alu_wb_data  in  1/ADDR_W/DATA_W  ALU write-back request
- alu_wb_ready  out  1  ALU request granted (combinational)
- mem_wb_valid / mem_wb_addr / mem_wb_data  in  1/ADDR_W/DATA_W  memory write-back request
- mem_wb_ready  out  1  memory request granted (combinational)
- rf_we / rf_waddr / rf_wdata  out  1/ADDR_W/DATA_W  register-file write port (registered)
- drain_req  in  1  request to quiesce the pipeline
- drain_done  out  1  pipeline empty; held while in DONE
- sb_error  out  1  sticky flag: write-back to a register with no pending write

Behaviour:
- Reset values:
  - All counters 0; rf_we=0, rf_waddr=0, rf_wdata=0.
  - sb_error=0, drain_done=0, state=RUN, rr_last=MEM (ALU wins the first tie).
  - Reset mid-drain returns to RUN.
- Hazard = cnt[rs1]!=0 OR (dec_uses_rs2 AND cnt[rs2]!=0) OR (dec_writes_reg AND cnt[rd]==max).
- of_issue = if_valid AND state==RUN AND !hazard.
- of_stall = if_valid AND !of_issue.
- On of_issue with dec_writes_reg: cnt[rd] increments at the clock edge.
- Arbitration:
  - Single requester is granted.
  - Both valid: grant the side not in rr_last; rr_last updates on every grant.
  - Transfer occurs on valid AND ready. The requester holds addr/data stable until ready.
- Write latency:
  - An accepted transfer drives rf_we=1 with its addr/data in the next cycle (exactly 1 cycle).
  - rf_we=0 otherwise.
  - The register file commits at the end of the rf_we cycle.
- Decrement: cnt[rf_waddr] decrements at the end of each cycle with rf_we=1. A reader of that register stays stalled during the rf_we cycle and is released the cycle after.
- Simultaneous increment and decrement of the same register in one cycle: net count unchanged.
- Underflow: an accepted write-back whose addr has cnt==0 still performs the write. The counter stays 0 and sb_error sets until reset.
- Saturation: cnt never exceeds max; the issue stalls instead.
- FSM:
  - RUN -> DRAIN on drain_req.
  - DRAIN: of_issue forced 0; write-backs are still arbitrated.
  - DRAIN -> DONE when all counters are 0 AND rf_we==0 AND neither wb_valid is asserted.
  - DONE: drain_done=1, no issue. DONE -> RUN when drain_req deasserts.
  - drain_req deasserted while in DRAIN: return to RUN.
- drain_done is registered: high from the first cycle in DONE until the cycle after leaving it.

Decomposition:
- Shared package (pipeline_pkg):
  - Instruction field bit positions (RS1_LSB=12, RS2_LSB=16, RD_LSB=20).
  - ADDR_W, DATA_W, NUM_REGS.
  - FSM state encoding: RUN=2'd0, DRAIN=2'd1, DONE=2'd2.
- Sub-module wb_rr_arbiter: two-requester round-robin with rr_last state, ready outputs and grant-select output.
- Scoreboard counters and FSM stay in the top module.

Test Plan:
1. Issue rd=5 (writes) then an instruction reading rs1=5 -> second instruction stalled. ALU wb addr 5 data 64'hA5 accepted at cycle T -> rf_we=1, waddr=5 at T+1. Stall drops at T+2, cnt[5]=0.
2. ALU and MEM both valid every cycle (addr 1 and 2, each pre-issued 3 times) -> grants alternate ALU, MEM, ALU, ... starting with ALU after reset. rf_waddr sequence 1,2,1,2,1,2.
3. Three issues to rd=7 with no write-back -> 4th write to rd=7 stalled (cnt=3). The same cycle's issue reading rs2=7 with dec_uses_rs2=0 and rd=3 issues.
4. Issue to rd=4 in the same cycle rf_we writes reg 4 (cnt was 1) -> cnt[4] stays 1, and a reader of r4 remains stalled.
5. MEM wb to addr 9 with cnt[9]=0 -> rf write occurs, sb_error=1 and stays 1 until reset.
6. drain_req with cnt[2]=1 -> of_issue=0 while draining. The wb for reg 2 completes, then drain_done=1. Deassert drain_req -> RUN next cycle. Asserting reset while in DRAIN -> state RUN, all outputs at reset values.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared constants for the operand-fetch scheduler
package pipeline_pkg;

  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 64;

  // Instruction field positions inside if_instr
  localparam int RS1_LSB = 12;
  localparam int RS2_LSB = 16;
  localparam int RD_LSB  = 20;

  typedef logic [1:0] sched_state_t;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

endpackage

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - two-requester round-robin arbiter for the write port
module wb_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic alu_valid,
  input  logic mem_valid,
  output logic alu_ready,
  output logic mem_ready,
  output logic grant_mem
);

  // 1 = the last grant went to MEM, so ALU wins the next tie
  logic rr_last_mem;

  assign alu_ready = alu_valid && (!mem_valid || rr_last_mem);
  assign mem_ready = mem_valid && !alu_ready;
  assign grant_mem = mem_ready;

  // Remember who was served last so ties alternate
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_last_mem <= 1'b1;
    end else if (alu_ready) begin
      rr_last_mem <= 1'b0;
    end else if (mem_ready) begin
      rr_last_mem <= 1'b1;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - scoreboard, write-port arbitration and drain control
module regfile_wb_scheduler #(
  parameter int NUM_REGS = pipeline_pkg::NUM_REGS,
  parameter int ADDR_W   = pipeline_pkg::ADDR_W,
  parameter int DATA_W   = pipeline_pkg::DATA_W,
  parameter int CNT_W    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [23:0]       if_instr,
  input  logic              dec_writes_reg,
  input  logic              dec_uses_rs2,
  output logic              of_issue,
  output logic              of_stall,
  input  logic              alu_wb_valid,
  input  logic [ADDR_W-1:0] alu_wb_addr,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [ADDR_W-1:0] mem_wb_addr,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              drain_req,
  output logic              drain_done,
  output logic              sb_error
);

  import pipeline_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0]    cnt [NUM_REGS];
  logic [NUM_REGS-1:0] inc_vec;
  logic [NUM_REGS-1:0] dec_vec;
  logic [ADDR_W-1:0]   rs1, rs2, rd;
  logic [1:0]          state, state_nx;
  logic                hazard, all_zero, wb_fire, grant_mem;
  logic                unused_instr_bits;

  assign rs1 = if_instr[RS1_LSB +: ADDR_W];
  assign rs2 = if_instr[RS2_LSB +: ADDR_W];
  assign rd  = if_instr[RD_LSB +: ADDR_W];
  assign unused_instr_bits = ^if_instr[RS1_LSB-1:0];

  assign hazard = (cnt[rs1] != '0)
                || (dec_uses_rs2 && (cnt[rs2] != '0))
                || (dec_writes_reg && (cnt[rd] == CNT_MAX));

  assign of_issue = if_valid && (state == ST_RUN) && !hazard;
  assign of_stall = if_valid && !of_issue;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .alu_valid (alu_wb_valid),
    .mem_valid (mem_wb_valid),
    .alu_ready (alu_wb_ready),
    .mem_ready (mem_wb_ready),
    .grant_mem (grant_mem)
  );

  assign wb_fire = (alu_wb_valid && alu_wb_ready) || (mem_wb_valid && mem_wb_ready);

  // Register the granted transfer onto the register-file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_we <= wb_fire;
      if (wb_fire) begin
        rf_waddr <= grant_mem ? mem_wb_addr : alu_wb_addr;
        rf_wdata <= grant_mem ? mem_wb_data : alu_wb_data;
      end
    end
  end

  // Per-register increment on issue, decrement when the write commits (never below 0)
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (of_issue && dec_writes_reg) inc_vec[rd] = 1'b1;
    if (rf_we && (cnt[rf_waddr] != '0)) dec_vec[rf_waddr] = 1'b1;
  end

  // Pending-write counters; simultaneous inc and dec cancel out
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (reset) begin
        cnt[i] <= '0;
      end else if (inc_vec[i] && !dec_vec[i]) begin
        cnt[i] <= cnt[i] + 1'b1;
      end else if (dec_vec[i] && !inc_vec[i]) begin
        cnt[i] <= cnt[i] - 1'b1;
      end
    end
  end

  // Sticky flag for a committed write nobody was waiting for
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_error <= 1'b0;
    end else if (rf_we && (cnt[rf_waddr] == '0)) begin
      sb_error <= 1'b1;
    end
  end

  // Scoreboard is empty when no register has a write in flight
  always_comb begin
    all_zero = 1'b1;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cnt[i] != '0) all_zero = 1'b0;
    end
  end

  // Drain sequencing: stop issue, wait for every write to land, then report done
  always_comb begin
    state_nx = state;
    case (state)
      ST_RUN:   if (drain_req) state_nx = ST_DRAIN;
      ST_DRAIN: begin
        if (!drain_req) begin
          state_nx = ST_RUN;
        end else if (all_zero && !rf_we && !alu_wb_valid && !mem_wb_valid) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE:  if (!drain_req) state_nx = ST_RUN;
      default:  state_nx = ST_RUN;
    endcase
  end

  // State register with drain_done registered alongside it
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_RUN;
      drain_done <= 1'b0;
    end else begin
      state      <= state_nx;
      drain_done <= (state_nx == ST_DONE);
    end
  end

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - scoreboard bench for regfile_wb_scheduler
`timescale 1ns/1ps
module tb_regfile_wb_scheduler;

  localparam int MAXC = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_valid;
  logic [23:0] if_instr;
  logic        dec_writes_reg, dec_uses_rs2;
  logic        of_issue, of_stall;
  logic        alu_wb_valid, alu_wb_ready;
  logic [3:0]  alu_wb_addr;
  logic [63:0] alu_wb_data;
  logic        mem_wb_valid, mem_wb_ready;
  logic [3:0]  mem_wb_addr;
  logic [63:0] mem_wb_data;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic        drain_req, drain_done, sb_error;

  regfile_wb_scheduler dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_instr(if_instr),
    .dec_writes_reg(dec_writes_reg), .dec_uses_rs2(dec_uses_rs2),
    .of_issue(of_issue), .of_stall(of_stall),
    .alu_wb_valid(alu_wb_valid), .alu_wb_addr(alu_wb_addr), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .drain_req(drain_req), .drain_done(drain_done), .sb_error(sb_error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  typedef enum {RUN_S, DRAIN_S, DONE_S} mstate_t;
  typedef struct {int due; logic [3:0] a; logic [63:0] d;} wr_t;

  wr_t        exp_q[$];
  logic [3:0] seen_q[$];
  int         m_cnt [16];
  bit         m_err = 0, m_rr_mem = 1, m_inf = 0;
  mstate_t    m_state = RUN_S;
  logic [3:0] m_inf_a;
  logic [63:0] m_inf_d;
  int         m_cyc = 0, mon_cyc = 0;
  bit         last_ar, last_mr, last_stall;
  bit         e_issue, e_stall, e_ar, e_mr, haz, all0;
  logic [3:0] f1, f2, fd;
  wr_t        wr_new;

  // Model: predict handshakes and flags from pending-write counts, push accepted writes
  always @(negedge clk) begin
    f1 = if_instr[15:12];
    f2 = if_instr[19:16];
    fd = if_instr[23:20];
    haz = (m_cnt[f1] != 0) || (dec_uses_rs2 && m_cnt[f2] != 0) ||
          (dec_writes_reg && m_cnt[fd] == MAXC);
    e_issue = if_valid && (m_state == RUN_S) && !haz;
    e_stall = if_valid && !e_issue;
    if (alu_wb_valid && mem_wb_valid) begin
      e_ar = m_rr_mem;
      e_mr = !m_rr_mem;
    end else begin
      e_ar = alu_wb_valid;
      e_mr = mem_wb_valid;
    end
    if (chk_en) begin
      chk("of_issue", of_issue, e_issue);
      chk("of_stall", of_stall, e_stall);
      chk("alu_ready", alu_wb_ready, e_ar);
      chk("mem_ready", mem_wb_ready, e_mr);
      chk("drain_done", drain_done, m_state == DONE_S);
      chk("sb_error", sb_error, m_err);
    end
    last_ar = e_ar;
    last_mr = e_mr;
    last_stall = e_stall;
    if (reset) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_err = 0; m_rr_mem = 1; m_inf = 0; m_state = RUN_S;
    end else begin
      all0 = 1;
      foreach (m_cnt[i]) if (m_cnt[i] != 0) all0 = 0;
      case (m_state)
        RUN_S:   if (drain_req) m_state = DRAIN_S;
        DRAIN_S: if (!drain_req) m_state = RUN_S;
                 else if (all0 && !m_inf && !alu_wb_valid && !mem_wb_valid) m_state = DONE_S;
        default: if (!drain_req) m_state = RUN_S;
      endcase
      if (m_inf) begin
        if (m_cnt[m_inf_a] == 0) m_err = 1;
        else m_cnt[m_inf_a]--;
      end
      if (e_issue && dec_writes_reg) m_cnt[fd]++;
      m_inf = 0;
      if (e_ar) begin
        m_inf = 1; m_inf_a = alu_wb_addr; m_inf_d = alu_wb_data; m_rr_mem = 0;
      end else if (e_mr) begin
        m_inf = 1; m_inf_a = mem_wb_addr; m_inf_d = mem_wb_data; m_rr_mem = 1;
      end
      if (m_inf) begin
        wr_new.due = m_cyc + 1; wr_new.a = m_inf_a; wr_new.d = m_inf_d;
        exp_q.push_back(wr_new);
      end
    end
    if (chk_en) m_cyc++;
  end

  wr_t mon_e;
  // Monitor: every register-file write must match the oldest accepted transfer, one cycle later
  always @(negedge clk) begin
    if (chk_en) begin
      if (rf_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("wr_unexpected", rf_we, 1'b0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("wr_cycle", mon_cyc, mon_e.due);
          chk("wr_addr", rf_waddr, mon_e.a);
          chk("wr_data", rf_wdata, mon_e.d);
          seen_q.push_back(rf_waddr);
        end
      end else if (exp_q.size() != 0 && exp_q[0].due <= mon_cyc) begin
        chk("wr_missing", rf_we, 1'b1);
        void'(exp_q.pop_front());
      end
      mon_cyc++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input bit v, input logic [3:0] s1, input logic [3:0] s2,
                           input logic [3:0] d, input bit wr, input bit u2);
    logic [11:0] lo;
    lo = 12'($urandom);
    if_valid = v;
    if_instr = {d, s2, s1, lo};
    dec_writes_reg = wr;
    dec_uses_rs2 = u2;
  endtask

  task automatic clear_inputs();
    if_valid = 0; if_instr = '0; dec_writes_reg = 0; dec_uses_rs2 = 0;
    alu_wb_valid = 0; alu_wb_addr = '0; alu_wb_data = '0;
    mem_wb_valid = 0; mem_wb_addr = '0; mem_wb_data = '0;
    drain_req = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    clear_inputs();
    tick();
    reset = 0;
  endtask

  // Present a write-back and hold it until granted; returns in the rf_we cycle
  task automatic alu_req(input logic [3:0] a, input logic [63:0] d);
    int g;
    alu_wb_valid = 1; alu_wb_addr = a; alu_wb_data = d;
    g = 0;
    do begin tick(); g++; end while (!last_ar && g < 20);
    if (!last_ar) begin total++; bad++; $display("FAIL alu_req_timeout addr=%0h", a); end
    alu_wb_valid = 0;
  endtask

  task automatic mem_req(input logic [3:0] a, input logic [63:0] d);
    int g;
    mem_wb_valid = 1; mem_wb_addr = a; mem_wb_data = d;
    g = 0;
    do begin tick(); g++; end while (!last_mr && g < 20);
    if (!last_mr) begin total++; bad++; $display("FAIL mem_req_timeout addr=%0h", a); end
    mem_wb_valid = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int ga, gm, guard;
    logic [3:0] a;
    int exp_seq [6];
    exp_seq = '{1, 2, 1, 2, 1, 2};
    reset = 1;
    clear_inputs();
    tick();
    chk_en = 1;
    tick();
    reset = 0;
    #1;
    chk("rst_rf_we", rf_we, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_err", sb_error, 0);
    chk("rst_done", drain_done, 0);

    // 1: RAW stall released two cycles after the write-back is accepted
    set_instr(1, 0, 0, 5, 1, 0);
    tick();
    set_instr(1, 5, 0, 0, 0, 0);
    #1 chk("t1_stall", of_stall, 1);
    alu_req(5, 64'hA5);
    #1;
    chk("t1_rf_we", rf_we, 1);
    chk("t1_waddr", rf_waddr, 5);
    chk("t1_wdata", rf_wdata, 64'hA5);
    chk("t1_still_stall", of_stall, 1);
    tick();
    #1 chk("t1_release", of_issue, 1);
    if_valid = 0;
    do_reset();
    #1 chk("t1_rst_waddr", rf_waddr, 0);
    chk("t1_rst_wdata", rf_wdata, 0);

    // 2: simultaneous requesters alternate starting with ALU
    for (int i = 0; i < 6; i++) begin
      set_instr(1, 0, 0, (i < 3) ? 4'd1 : 4'd2, 1, 0);
      tick();
    end
    if_valid = 0;
    seen_q.delete();
    alu_wb_valid = 1; alu_wb_addr = 1; alu_wb_data = 64'h100;
    mem_wb_valid = 1; mem_wb_addr = 2; mem_wb_data = 64'h200;
    ga = 0; gm = 0; guard = 0;
    while ((ga < 3 || gm < 3) && guard < 30) begin
      tick();
      guard++;
      if (last_ar) begin
        ga++;
        if (ga == 3) alu_wb_valid = 0; else alu_wb_data = alu_wb_data + 1;
      end
      if (last_mr) begin
        gm++;
        if (gm == 3) mem_wb_valid = 0; else mem_wb_data = mem_wb_data + 1;
      end
    end
    tick(); tick();
    chk("t2_count", seen_q.size(), 6);
    for (int i = 0; i < 6 && i < seen_q.size(); i++) chk("t2_seq", seen_q[i], exp_seq[i]);

    // 3: saturation stalls a 4th writer; an unread rs2 does not block
    for (int i = 0; i < 3; i++) begin
      set_instr(1, 0, 0, 7, 1, 0);
      tick();
    end
    set_instr(1, 0, 0, 7, 1, 0);
    #1 chk("t3_sat_stall", of_stall, 1);
    set_instr(1, 0, 7, 3, 1, 0);
    #1 chk("t3_rs2_unused", of_issue, 1);
    tick();
    if_valid = 0;
    do_reset();

    // 4: issue and commit to the same register in one cycle
    set_instr(1, 0, 0, 4, 1, 0);
    tick();
    if_valid = 0;
    alu_req(4, 64'h44);
    set_instr(1, 0, 0, 4, 1, 0);
    #1 chk("t4_rf_we", rf_we, 1);
    chk("t4_issue", of_issue, 1);
    tick();
    set_instr(1, 4, 0, 0, 0, 0);
    #1 chk("t4_reader_stall", of_stall, 1);
    tick();
    #1 chk("t4_reader_stall2", of_stall, 1);
    if_valid = 0;
    do_reset();

    // 5: write-back with no pending write is still performed and flagged
    mem_req(9, 64'h99);
    #1 chk("t5_rf_we", rf_we, 1);
    chk("t5_waddr", rf_waddr, 9);
    tick();
    #1 chk("t5_err", sb_error, 1);
    repeat (5) tick();
    chk("t5_err_sticky", sb_error, 1);
    do_reset();
    #1 chk("t5_err_cleared", sb_error, 0);

    // 6: drain handshake and reset out of DRAIN
    set_instr(1, 0, 0, 2, 1, 0);
    tick();
    if_valid = 0;
    drain_req = 1;
    tick();
    set_instr(1, 0, 0, 0, 0, 0);
    #1 chk("t6_no_issue", of_issue, 0);
    alu_req(2, 64'h22);
    guard = 0;
    do begin tick(); guard++; end while (!drain_done && guard < 10);
    chk("t6_done", drain_done, 1);
    drain_req = 0;
    tick();
    #1 chk("t6_run_issue", of_issue, 1);
    chk("t6_done_low", drain_done, 0);
    set_instr(1, 0, 0, 2, 1, 0);
    tick();
    drain_req = 1;
    set_instr(1, 0, 0, 0, 0, 0);
    tick();
    #1 chk("t6_drain_block", of_issue, 0);
    reset = 1;
    tick();
    reset = 0;
    #1;
    chk("t6_rst_issue", of_issue, 1);
    chk("t6_rst_done", drain_done, 0);
    chk("t6_rst_rf_we", rf_we, 0);
    chk("t6_rst_waddr", rf_waddr, 0);
    chk("t6_rst_wdata", rf_wdata, 0);
    chk("t6_rst_err", sb_error, 0);
    do_reset();

    // Randomized traffic against the model
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) begin
        do_reset();
      end else begin
        tick();
      end
      if (!if_valid || !last_stall) begin
        set_instr($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  4'($urandom_range(0, 7)), 1'($urandom), 1'($urandom));
      end
      if (!alu_wb_valid || last_ar) begin
        a = 4'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0 && (m_cnt[a] != 0 || $urandom_range(0, 15) == 0)) begin
          alu_wb_valid = 1; alu_wb_addr = a; alu_wb_data = {$urandom, $urandom};
        end else begin
          alu_wb_valid = 0;
        end
      end
      if (!mem_wb_valid || last_mr) begin
        a = 4'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0 && (m_cnt[a] != 0 || $urandom_range(0, 15) == 0)) begin
          mem_wb_valid = 1; mem_wb_addr = a; mem_wb_data = {$urandom, $urandom};
        end else begin
          mem_wb_valid = 0;
        end
      end
      if ($urandom_range(0, 49) == 0) drain_req = !drain_req;
    end

    clear_inputs();
    repeat (4) tick();
    chk("q_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
